// File: rtl/sdram_term_tracker_pkg.sv
// sdram_term_tracker_pkg: sequencer command encoding and address field helpers
// shared by the STERM tracker and its speculative-read CAM.
package sdram_term_tracker_pkg;

    typedef enum logic [2:0] {
        CMD_RESET    = 3'b000,
        CMD_ACT      = 3'b001,
        CMD_PRE      = 3'b010,
        CMD_PRE_ALL  = 3'b011,
        CMD_NOP      = 3'b100,
        CMD_SPEC_INS = 3'b101,
        CMD_SPEC_CLR = 3'b110,
        CMD_REFRESH  = 3'b111
    } cmd_e;

    // Tags cover A[30:2]; A[31] selects the non-RAM window and never takes part.
    localparam int TAG_W = 29;

    function automatic int bank_lsb();
        return 2;
    endfunction

    function automatic int row_lsb(input int bank_bits, input int col_bits);
        return 2 + bank_bits + col_bits;
    endfunction

endpackage

// File: rtl/sdram_spec_cam.sv
// sdram_spec_cam: small fully-associative tag store of speculatively read longwords
// with lookup, insert, write invalidate and round-robin replacement.
module sdram_spec_cam
    import sdram_term_tracker_pkg::*;
#(
    parameter int ENTRIES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] tag,
    input  logic             ins,
    input  logic             inv,
    input  logic             clr,
    output logic             hit
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0]            vld_q, vld_d, match;
    logic [PW-1:0]                 ptr_q, ptr_d;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) match[i] = vld_q[i] && (tag_q[i] == tag);
    end

    assign hit = |match;

    // A write to the same tag in the insert cycle suppresses the insert entirely.
    always_comb begin
        tag_d = tag_q;
        vld_d = inv ? (vld_q & ~match) : vld_q;
        ptr_d = ptr_q;
        if (ins && !hit && !inv) begin
            tag_d[ptr_q] = tag;
            vld_d[ptr_q] = 1'b1;
            ptr_d        = (ptr_q == PW'(ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
        end
        if (clr) vld_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            vld_q <= '0;
            ptr_q <= '0;
        end else begin
            tag_q <= tag_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sdram_term_tracker.sv
// sdram_term_tracker: early-STERM generator for the SDRAM window (open-row writes,
// speculative-read hits, sequencer STERMin) plus refresh timer. CAM built under STERM_SPEC_EN.
module sdram_term_tracker
    import sdram_term_tracker_pkg::*;
#(
    parameter int  BANK_BITS    = 2,
    parameter int  COL_BITS     = 9,
    parameter int  ROW_BITS     = 13,
    parameter int  SPEC_ENTRIES = 2,
    parameter int  REF_INTERVAL = 1560,
    localparam int NBANK        = 2 ** BANK_BITS
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic [31:2]      A,
    input  logic             nWE,
    input  logic             SEL,
    input  logic             STERMin,
    input  logic [2:0]       CMD,
    output logic             nSTERM,
    output logic             RefReq,
    output logic             RefUrgent,
    output logic [NBANK-1:0] BankOpen
);

    localparam int CW      = $clog2(REF_INTERVAL);
    localparam int ROW_LSB = row_lsb(BANK_BITS, COL_BITS);

    cmd_e                          cmd;
    logic [BANK_BITS-1:0]          bank;
    logic [ROW_BITS-1:0]           row;
    logic                          wr_cyc, rd_cyc, wr_hit, spec_hit;
    logic [NBANK-1:0]              open_q, open_d;
    logic [NBANK-1:0][ROW_BITS-1:0] row_q, row_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          req_q, req_d, urg_q, urg_d;

    assign cmd    = cmd_e'(CMD);
    assign bank   = A[bank_lsb() +: BANK_BITS];
    assign row    = A[ROW_LSB +: ROW_BITS];
    assign wr_cyc = SEL & ~nWE & ~A[31];
    assign rd_cyc = SEL & nWE & ~A[31];
    assign wr_hit = wr_cyc & open_q[bank] & (row_q[bank] == row) & ~urg_q;
    assign nSTERM = ~(STERMin | spec_hit | wr_hit);

    assign BankOpen  = open_q;
    assign RefReq    = req_q;
    assign RefUrgent = urg_q;

`ifdef STERM_SPEC_EN
    logic cam_hit;

    sdram_spec_cam #(.ENTRIES(SPEC_ENTRIES)) u_cam (
        .clk   (CLK),
        .rst_n (nRESET),
        .tag   (A[30:2]),
        .ins   (cmd == CMD_SPEC_INS),
        .inv   (wr_cyc),
        .clr   (cmd == CMD_SPEC_CLR || cmd == CMD_RESET || cmd == CMD_REFRESH),
        .hit   (cam_hit)
    );

    assign spec_hit = rd_cyc & cam_hit;
`else
    logic unused_a;

    assign unused_a = ^{A[30:2], rd_cyc};
    assign spec_hit = 1'b0;
`endif

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        cnt_d  = (cnt_q == '0) ? CW'(REF_INTERVAL - 1) : cnt_q - 1'b1;
        req_d  = req_q | (cnt_q == '0);
        urg_d  = urg_q | ((cnt_q == '0) & req_q);
        if (cmd == CMD_ACT) begin
            open_d[bank] = 1'b1;
            row_d[bank]  = row;
        end
        if (cmd == CMD_PRE) open_d[bank] = 1'b0;
        if (cmd == CMD_PRE_ALL || cmd == CMD_RESET) open_d = '0;
        if (cmd == CMD_REFRESH) begin
            open_d = '0;
            cnt_d  = CW'(REF_INTERVAL - 1);
            req_d  = 1'b0;
            urg_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            open_q <= '0;
            row_q  <= '0;
            cnt_q  <= CW'(REF_INTERVAL - 1);
            req_q  <= 1'b0;
            urg_q  <= 1'b0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            urg_q  <= urg_d;
        end
    end

endmodule

// File: tb/tb_sdram_term_tracker.sv
// tb_sdram_term_tracker: directed vectors for the STERM tracker with REF_INTERVAL=16;
// CAM vectors run when STERM_SPEC_EN is defined, the CAM-less vectors otherwise.
module tb_sdram_term_tracker;
    import sdram_term_tracker_pkg::*;

    logic        CLK, nRESET, nWE, SEL, STERMin;
    logic [31:2] A;
    logic [2:0]  CMD;
    logic        nSTERM, RefReq, RefUrgent;
    logic [3:0]  BankOpen;
    int          n_checks = 0;
    int          n_fail   = 0;

    sdram_term_tracker #(.REF_INTERVAL(16)) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .A         (A),
        .nWE       (nWE),
        .SEL       (SEL),
        .STERMin   (STERMin),
        .CMD       (CMD),
        .nSTERM    (nSTERM),
        .RefReq    (RefReq),
        .RefUrgent (RefUrgent),
        .BankOpen  (BankOpen)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic sel, input logic we_n, input cmd_e c);
        A   = addr[31:2];
        SEL = sel;
        nWE = we_n;
        CMD = c;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic probe(input string tag, input logic [31:0] addr, input logic we_n, input logic exp);
        bus(addr, 1'b1, we_n, CMD_NOP);
        #1;
        check(tag, 32'(nSTERM), 32'(exp));
    endtask

    task automatic ins(input logic [31:0] addr);
        bus(addr, 1'b0, 1'b1, CMD_SPEC_INS);
        tick(1);
    endtask

    task automatic do_reset();
        nRESET  = 1'b0;
        STERMin = 1'b0;
        bus(32'h0, 1'b0, 1'b1, CMD_NOP);
        @(posedge CLK);
        #1;
        nRESET = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_bankopen", 32'(BankOpen), 32'h0);
        check("rst_refreq", 32'(RefReq), 32'h0);
        check("rst_refurgent", 32'(RefUrgent), 32'h0);
        check("rst_nsterm", 32'(nSTERM), 32'h1);

        bus(32'h0002_2004, 1'b0, 1'b1, CMD_ACT);
        tick(1);
        check("act_bank1", 32'(BankOpen), 32'h2);
        probe("wr_open_row", 32'h0002_2FF4, 1'b0, 1'b0);
        probe("wr_other_row", 32'h0004_2004, 1'b0, 1'b1);
        probe("wr_other_bank", 32'h0002_2000, 1'b0, 1'b1);
        probe("rd_open_row", 32'h0002_2FF4, 1'b1, 1'b1);
        probe("wr_a31", 32'h8002_2FF4, 1'b0, 1'b1);
        bus(32'h0, 1'b0, 1'b1, CMD_NOP);
        STERMin = 1'b1;
        #1;
        check("stermin_pass", 32'(nSTERM), 32'h0);
        STERMin = 1'b0;
        bus(32'h0000_0008, 1'b0, 1'b1, CMD_ACT);
        tick(1);
        check("act_bank2", 32'(BankOpen), 32'h6);
        bus(32'h0002_2004, 1'b0, 1'b1, CMD_PRE);
        tick(1);
        check("pre_bank1", 32'(BankOpen), 32'h4);
        bus(32'h0, 1'b0, 1'b1, CMD_PRE_ALL);
        tick(1);
        check("pre_all", 32'(BankOpen), 32'h0);

`ifdef STERM_SPEC_EN
        do_reset();
        ins(32'h100);
        ins(32'h200);
        ins(32'h300);
        probe("spec_evict_100", 32'h100, 1'b1, 1'b1);
        probe("spec_hit_200", 32'h200, 1'b1, 1'b0);
        probe("spec_hit_300", 32'h300, 1'b1, 1'b0);
        ins(32'h400);
        probe("spec_hit_400", 32'h400, 1'b1, 1'b0);
        probe("spec_evict_200", 32'h200, 1'b1, 1'b1);
        bus(32'h400, 1'b1, 1'b0, CMD_NOP);
        tick(1);
        probe("wr_inval_400", 32'h400, 1'b1, 1'b1);
        ins(32'h400);
        probe("spec_a31_miss", 32'h8000_0400, 1'b1, 1'b1);
        probe("spec_rehit_400", 32'h400, 1'b1, 1'b0);
        probe("spec_evict_300", 32'h300, 1'b1, 1'b1);
        ins(32'h400);
        ins(32'h500);
        probe("dup_keeps_400", 32'h400, 1'b1, 1'b0);
        probe("spec_hit_500", 32'h500, 1'b1, 1'b0);
        bus(32'h600, 1'b1, 1'b0, CMD_SPEC_INS);
        tick(1);
        probe("inv_wins_600", 32'h600, 1'b1, 1'b1);
        probe("inv_wins_keep_400", 32'h400, 1'b1, 1'b0);
        bus(32'h0, 1'b0, 1'b1, CMD_SPEC_CLR);
        tick(1);
        probe("spec_clr_400", 32'h400, 1'b1, 1'b1);
`else
        do_reset();
        ins(32'h100);
        probe("nospec_miss_100", 32'h100, 1'b1, 1'b1);
        STERMin = 1'b1;
        #1;
        check("nospec_stermin", 32'(nSTERM), 32'h0);
        STERMin = 1'b0;
`endif

        do_reset();
        bus(32'h0002_2004, 1'b0, 1'b1, CMD_ACT);
        tick(1);
        bus(32'h0, 1'b0, 1'b1, CMD_NOP);
        tick(14);
        check("refreq_clk15", 32'(RefReq), 32'h0);
        tick(1);
        check("refreq_clk16", 32'(RefReq), 32'h1);
        check("urgent_clk16", 32'(RefUrgent), 32'h0);
        probe("wr_hit_pre_urgent", 32'h0002_2FF4, 1'b0, 1'b0);
        tick(15);
        check("urgent_clk31", 32'(RefUrgent), 32'h0);
        tick(1);
        check("urgent_clk32", 32'(RefUrgent), 32'h1);
        check("refreq_clk32", 32'(RefReq), 32'h1);
        check("urgent_blocks_wr", 32'(nSTERM), 32'h1);
        STERMin = 1'b1;
        #1;
        check("urgent_stermin", 32'(nSTERM), 32'h0);
        STERMin = 1'b0;
        bus(32'h0, 1'b0, 1'b1, CMD_REFRESH);
        tick(1);
        check("aref_bankopen", 32'(BankOpen), 32'h0);
        check("aref_refreq", 32'(RefReq), 32'h0);
        check("aref_urgent", 32'(RefUrgent), 32'h0);
        bus(32'h0, 1'b0, 1'b1, CMD_NOP);
        tick(15);
        check("aref_reload_15", 32'(RefReq), 32'h0);
        tick(1);
        check("aref_reload_16", 32'(RefReq), 32'h1);

        bus(32'h0002_2004, 1'b0, 1'b1, CMD_ACT);
        tick(1);
        check("pre_arst_bank", 32'(BankOpen), 32'h2);
`ifdef STERM_SPEC_EN
        ins(32'h700);
        probe("pre_arst_spec", 32'h700, 1'b1, 1'b0);
`endif
        @(posedge CLK);
        #3;
        nRESET = 1'b0;
        #1;
        check("arst_bankopen", 32'(BankOpen), 32'h0);
        check("arst_refreq", 32'(RefReq), 32'h0);
        check("arst_urgent", 32'(RefUrgent), 32'h0);
        probe("arst_spec_miss", 32'h700, 1'b1, 1'b1);
        probe("arst_wr_miss", 32'h0002_2FF4, 1'b0, 1'b1);
        nRESET = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
